// File: rtl/pcm_chan_fifo_pkg.sv
// Shared widths for the PCM channel capture FIFO.
package pcm_chan_fifo_pkg;
  localparam int PCM_W    = 16;
  localparam int CHOOSE_W = 8;
  localparam int SEP_W    = 8;
endpackage

// File: rtl/pcm_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head word.
module pcm_sync_fifo
  import pcm_chan_fifo_pkg::*;
#(
  parameter int pcmaw = 1
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [PCM_W-1:0] din,
  output logic [PCM_W-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic [pcmaw:0]   count
);
  localparam int DEPTH = 1 << pcmaw;

  logic [PCM_W-1:0] mem [DEPTH];
  logic [pcmaw-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [pcmaw:0]   cnt, cnt_rem, cnt_nxt;
  logic [PCM_W-1:0] head;
  logic             push_en, pop_en;

  // Occupancy never exceeds DEPTH, so its MSB alone marks full.
  assign full    = cnt[pcmaw];
  assign valid   = (cnt != '0);
  assign count   = cnt;
  assign dout    = head;
  assign push_en = push & ~full & ~flush;
  assign pop_en  = pop & valid & ~flush;
  assign rd_nxt  = rd_ptr + pcmaw'(pop_en);
  assign cnt_rem = cnt - (pcmaw+1)'(pop_en);
  assign cnt_nxt = cnt_rem + (pcmaw+1)'(push_en);

  always_ff @(posedge clk1) begin
    if (push_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      head   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + pcmaw'(push_en);
      rd_ptr <= rd_nxt;
      cnt    <= cnt_nxt;
      // Head follows the next-to-read entry; it bypasses din when the FIFO
      // would otherwise be empty, and holds the last popped word when empty.
      if (cnt_nxt != '0) head <= (cnt_rem == '0) ? din : mem[rd_nxt];
    end
  end
endmodule

// File: rtl/pcm_chan_fifo.sv
// Captures one selected PCM lane, decimated by a skip count, into a small FIFO.
module pcm_chan_fifo
  import pcm_chan_fifo_pkg::*;
#(
  parameter int CHANNEL = 6,
  parameter int pcmaw   = 1
) (
  input  logic                     clk1,
  input  logic                     rst,
  input  logic [CHANNEL*PCM_W-1:0] pcm_in,
  input  logic [CHANNEL-1:0]       pcm_in_valid,
  output logic [CHANNEL-1:0]       pcm_in_ready,
  output logic [PCM_W-1:0]         pcm_out,
  output logic                     pcm_out_valid,
  input  logic                     pcm_out_ready,
  input  logic [CHOOSE_W-1:0]      pcm_channel_choose,
  input  logic [SEP_W-1:0]         pcm_capture_sep,
  output logic [pcmaw:0]           pcm_available
);
  logic [PCM_W-1:0]    lane_data;
  logic                lane_vld, sel_ok, full, evt, chg, push;
  logic [CHOOSE_W-1:0] sel_q;
  logic                sel_seen;
  logic [SEP_W-1:0]    skip_q;

  always_comb begin
    lane_data = '0;
    lane_vld  = 1'b0;
    for (int k = 0; k < CHANNEL; k++) begin
      if (pcm_channel_choose == CHOOSE_W'(k)) begin
        lane_data = pcm_in[PCM_W*k +: PCM_W];
        lane_vld  = pcm_in_valid[k];
      end
    end
  end

  for (genvar k = 0; k < CHANNEL; k++) begin : g_rdy
    assign pcm_in_ready[k] = ~(full && pcm_channel_choose == CHOOSE_W'(k));
  end

  assign sel_ok = (pcm_channel_choose < CHOOSE_W'(CHANNEL));
  assign evt    = sel_ok & lane_vld & ~full;
  // The first edge after reset has no previous selection to compare with.
  assign chg    = sel_seen & (pcm_channel_choose != sel_q);
  assign push   = evt & (skip_q == '0) & ~chg;

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      sel_q    <= '0;
      sel_seen <= 1'b0;
      skip_q   <= '0;
    end else begin
      sel_q    <= pcm_channel_choose;
      sel_seen <= 1'b1;
      if (chg)      skip_q <= '0;
      else if (evt) skip_q <= (skip_q == '0) ? pcm_capture_sep : skip_q - 1'b1;
    end
  end

  pcm_sync_fifo #(.pcmaw(pcmaw)) u_fifo (
    .clk1  (clk1),
    .rst   (rst),
    .push  (push),
    .pop   (pcm_out_ready),
    .flush (chg),
    .din   (lane_data),
    .dout  (pcm_out),
    .valid (pcm_out_valid),
    .full  (full),
    .count (pcm_available)
  );
endmodule

// File: tb/tb_pcm_chan_fifo.sv
// Directed bench for pcm_chan_fifo with CHANNEL=6, pcmaw=1.
module tb_pcm_chan_fifo;
  localparam int CH = 6;
  localparam int AW = 1;

  logic           clk1 = 1'b0;
  logic           rst  = 1'b0;
  logic [CH*16-1:0] pcm_in = '0;
  logic [CH-1:0]  pcm_in_valid = '0;
  logic [CH-1:0]  pcm_in_ready;
  logic [15:0]    pcm_out;
  logic           pcm_out_valid;
  logic           pcm_out_ready = 1'b0;
  logic [7:0]     pcm_channel_choose = '0;
  logic [7:0]     pcm_capture_sep = '0;
  logic [AW:0]    pcm_available;

  int vectors = 0;
  int errors  = 0;

  pcm_chan_fifo #(.CHANNEL(CH), .pcmaw(AW)) dut (
    .clk1(clk1), .rst(rst), .pcm_in(pcm_in), .pcm_in_valid(pcm_in_valid),
    .pcm_in_ready(pcm_in_ready), .pcm_out(pcm_out), .pcm_out_valid(pcm_out_valid),
    .pcm_out_ready(pcm_out_ready), .pcm_channel_choose(pcm_channel_choose),
    .pcm_capture_sep(pcm_capture_sep), .pcm_available(pcm_available)
  );

  always #5 clk1 = ~clk1;

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic set_lanes(input logic [15:0] v);
    for (int k = 0; k < CH; k++) pcm_in[16*k +: 16] = v ^ 16'(k * 16'h0101);
  endtask

  task automatic set_lane(input int k, input logic [15:0] v);
    pcm_in[16*k +: 16] = v;
  endtask

  task automatic test_reset();
    #2;
    vectors++; if (pcm_out !== 16'h0) begin errors++; $display("FAIL reset_out got %h exp 0000", pcm_out); end
    vectors++; if (pcm_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", pcm_out_valid); end
    vectors++; if (pcm_available !== 2'd0) begin errors++; $display("FAIL reset_avail got %0d exp 0", pcm_available); end
    vectors++; if (pcm_in_ready !== 6'h3F) begin errors++; $display("FAIL reset_ready got %h exp 3f", pcm_in_ready); end
    step();
    rst = 1'b1;
  endtask

  task automatic test_fill();
    logic [15:0] vals [3] = '{16'h1111, 16'h2222, 16'h3333};
    logic [1:0]  exp_av [3] = '{2'd1, 2'd2, 2'd2};
    pcm_channel_choose = 8'd2;
    pcm_capture_sep    = 8'd0;
    pcm_out_ready      = 1'b0;
    set_lanes(16'hAAAA);
    pcm_in_valid = 6'b000100;
    for (int i = 0; i < 3; i++) begin
      set_lane(2, vals[i]);
      step();
      vectors++; if (pcm_available !== exp_av[i]) begin errors++; $display("FAIL fill_avail[%0d] got %0d exp %0d", i, pcm_available, exp_av[i]); end
      vectors++; if (pcm_out !== 16'h1111 || pcm_out_valid !== 1'b1) begin errors++; $display("FAIL fill_head[%0d] got %h/%b exp 1111/1", i, pcm_out, pcm_out_valid); end
      vectors++; if (pcm_in_ready !== ((exp_av[i] == 2'd2) ? 6'h3B : 6'h3F)) begin errors++; $display("FAIL fill_ready[%0d] got %h", i, pcm_in_ready); end
    end
  endtask

  task automatic test_drain();
    logic [15:0] exp_out [3] = '{16'h2222, 16'h3333, 16'h3333};
    logic [1:0]  exp_av  [3] = '{2'd1, 2'd1, 2'd0};
    pcm_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 1) pcm_in_valid = '0;
      vectors++; if (pcm_out !== exp_out[i]) begin errors++; $display("FAIL drain_out[%0d] got %h exp %h", i, pcm_out, exp_out[i]); end
      vectors++; if (pcm_available !== exp_av[i] || pcm_out_valid !== (exp_av[i] != 0)) begin errors++; $display("FAIL drain_cnt[%0d] got %0d/%b exp %0d", i, pcm_available, pcm_out_valid, exp_av[i]); end
    end
  endtask

  task automatic test_sep();
    logic [15:0] exp_o;
    pcm_channel_choose = 8'd0;
    pcm_capture_sep    = 8'd2;
    pcm_out_ready      = 1'b1;
    pcm_in_valid       = '0;
    step();
    pcm_in_valid = 6'b000001;
    for (int i = 1; i <= 9; i++) begin
      set_lane(0, 16'(i));
      step();
      exp_o = 16'(1 + 3 * ((i - 1) / 3));
      vectors++; if (pcm_out_valid !== (i % 3 == 1)) begin errors++; $display("FAIL sep_valid[%0d] got %b", i, pcm_out_valid); end
      vectors++; if (pcm_out !== exp_o) begin errors++; $display("FAIL sep_out[%0d] got %h exp %h", i, pcm_out, exp_o); end
    end
    pcm_in_valid = '0;
  endtask

  task automatic test_nosel();
    pcm_channel_choose = 8'd7;
    pcm_capture_sep    = 8'd0;
    pcm_out_ready      = 1'b0;
    pcm_in_valid       = 6'h3F;
    for (int i = 0; i < 4; i++) begin
      set_lanes(16'(16'h0100 + i));
      step();
      vectors++; if (pcm_in_ready !== 6'h3F) begin errors++; $display("FAIL nosel_ready[%0d] got %h exp 3f", i, pcm_in_ready); end
      vectors++; if (pcm_out_valid !== 1'b0 || pcm_available !== 2'd0) begin errors++; $display("FAIL nosel_valid[%0d] got %b/%0d exp 0/0", i, pcm_out_valid, pcm_available); end
    end
    pcm_in_valid = '0;
  endtask

  task automatic test_flush();
    pcm_channel_choose = 8'd0;
    step();
    pcm_in_valid = 6'b000001;
    set_lane(0, 16'h0A0A); step();
    set_lane(0, 16'h0B0B); step();
    vectors++; if (pcm_available !== 2'd2) begin errors++; $display("FAIL flush_pre got %0d exp 2", pcm_available); end
    pcm_channel_choose = 8'd1;
    pcm_in_valid = 6'b000010;
    set_lane(1, 16'h0C0C);
    step();
    vectors++; if (pcm_available !== 2'd0 || pcm_out_valid !== 1'b0) begin errors++; $display("FAIL flush_cnt got %0d/%b exp 0/0", pcm_available, pcm_out_valid); end
    step();
    vectors++; if (pcm_available !== 2'd1 || pcm_out !== 16'h0C0C) begin errors++; $display("FAIL flush_post got %0d/%h exp 1/0c0c", pcm_available, pcm_out); end
  endtask

  task automatic test_async_reset();
    set_lane(1, 16'h0D0D);
    step();
    vectors++; if (pcm_available !== 2'd2 || pcm_in_ready !== 6'h3D) begin errors++; $display("FAIL ar_full got %0d/%h exp 2/3d", pcm_available, pcm_in_ready); end
    #2 rst = 1'b0;
    #1;
    vectors++; if (pcm_out_valid !== 1'b0 || pcm_available !== 2'd0) begin errors++; $display("FAIL ar_clear got %b/%0d exp 0/0", pcm_out_valid, pcm_available); end
    vectors++; if (pcm_out !== 16'h0 || pcm_in_ready !== 6'h3F) begin errors++; $display("FAIL ar_out got %h/%h exp 0000/3f", pcm_out, pcm_in_ready); end
    step();
    set_lane(1, 16'h5A5A);
    rst = 1'b1;
    step();
    vectors++; if (pcm_out_valid !== 1'b1 || pcm_out !== 16'h5A5A || pcm_available !== 2'd1) begin errors++; $display("FAIL ar_first got %b/%h/%0d exp 1/5a5a/1", pcm_out_valid, pcm_out, pcm_available); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_sep();
    test_nosel();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/pcm_chan_fifo.md
PCM_CHAN_FIFO -- requirements
Module: pcm_chan_fifo

Interface
REQ-001 Parameter CHANNEL, default 6: number of 16-bit PCM input lanes, range 1..16.
REQ-002 Parameter pcmaw, default 1: FIFO address width; depth = 2^pcmaw entries of 16 bits.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk1  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous active-low reset; rst=0 resets the block.
REQ-006 pcm_in  in  CHANNEL*16  lane k occupies bits [16k+15:16k], two's complement.
REQ-007 pcm_in_valid  in  CHANNEL  per-lane sample strobe.
REQ-008 pcm_in_ready  out  CHANNEL  per-lane accept indication.
REQ-009 pcm_out  out  16  FIFO head sample.
REQ-010 pcm_out_valid  out  1  FIFO non-empty.
REQ-011 pcm_out_ready  in  1  consumer pop request.
REQ-012 pcm_channel_choose  in  8  selected lane index, unsigned.
REQ-013 pcm_capture_sep  in  8  number of selected-lane samples discarded after each captured sample.
REQ-014 pcm_available  out  pcmaw+1  current FIFO occupancy, 0..2^pcmaw.

Function
REQ-015 sel = pcm_channel_choose; sel >= CHANNEL selects no lane: nothing is captured and all pcm_in_ready bits are 1.
REQ-016 Unselected lanes: pcm_in_ready bit = 1; their samples are discarded.
REQ-017 Selected lane: pcm_in_ready = !full, where full means occupancy = 2^pcmaw; it does not depend on a same-cycle pop.
REQ-018 Sample event: pcm_in_valid[sel] && pcm_in_ready[sel] on a rising edge.
REQ-019 Skip counter: after each captured sample it loads pcm_capture_sep; each subsequent sample event decrements it and drops that sample; a sample event with the counter at 0 is pushed.
REQ-020 With sep=0 every sample event is pushed; with sep=N one sample in N+1 is pushed; the first event after reset or after a flush is always pushed.
REQ-021 Push writes pcm_in[16*sel+15:16*sel] at the write pointer, then increments the pointer modulo 2^pcmaw.
REQ-022 First-word-fall-through: pcm_out_valid = (occupancy != 0); pcm_out = head entry.
REQ-023 Latency: a sample pushed at edge N is visible on pcm_out/pcm_out_valid after edge N (registered, one cycle).
REQ-024 Pop: pcm_out_valid && pcm_out_ready on an edge advances the read pointer modulo 2^pcmaw; pcm_out_ready while empty has no effect.
REQ-025 Simultaneous push and pop: both occur and occupancy is unchanged; pop of the last entry with a push in the same cycle leaves valid = 1 with the new sample.
REQ-026 When empty, pcm_out holds the last popped value (0 after reset).
REQ-027 Change of pcm_channel_choose (value differs from the previous cycle): flush on that edge (pointers and occupancy to 0, skip counter to 0); any push in that cycle is discarded.
REQ-028 A change of pcm_capture_sep takes effect at the next counter load; it causes no flush.
REQ-029 No overflow or underflow is possible; samples offered while full stall through pcm_in_ready = 0.

Reset
REQ-030 rst=0 asynchronously clears pointers, occupancy, skip counter, the registered choose copy, and the head register.
REQ-031 Reset values: pcm_out = 0, pcm_out_valid = 0, pcm_available = 0, pcm_in_ready = all 1 (the FIFO is not full).
REQ-032 Reset asserted mid-operation discards all FIFO contents; the first sample event after release is pushed.

Structure
REQ-033 The shared package holds the PCM sample width constant (16) and the choose/sep field widths (8).
REQ-034 One sub-module, pcm_sync_fifo (single-clock FWFT storage, parameter pcmaw, with push, pop, flush and count); lane select and skip logic live in the top level.

Verification
REQ-035 CHANNEL=6, pcmaw=1, sel=2, sep=0, ready=0, push 0x1111, 0x2222, 0x3333 -> available 1, 2; pcm_in_ready[2]=0 at 2; 0x3333 stalls; other ready bits stay 1.
REQ-036 Then hold pcm_out_ready=1 -> outputs 0x1111, 0x2222, 0x3333 in order; valid drops when empty; pcm_out holds 0x3333.
REQ-037 sep=2, lane 0 valid every cycle with values 1..9, ready=1 -> pcm_out sequence 1, 4, 7.
REQ-038 sel=7 with CHANNEL=6 -> all ready bits 1, valid never asserts; sel change 0->1 with 2 entries queued -> available=0 on the next cycle.
REQ-039 rst pulled low asynchronously between edges while full -> valid=0, available=0, pcm_out=0 immediately; the first sample after release appears one cycle later.
